// File: rtl/dflow_pkg.sv
// Shared types and record layout for the dflow replay/store paths.
// A record is {five-tuple, packet length}, tuple in the upper bits.
package dflow_pkg;

    localparam int DFLOW_TUPLE_WIDTH = 104;
    localparam int DFLOW_LEN_WIDTH   = 16;
    localparam int RECORD_WIDTH      = DFLOW_TUPLE_WIDTH + DFLOW_LEN_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CAL,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } replay_state_t;

    function automatic logic [DFLOW_TUPLE_WIDTH-1:0] rec_tuple(input logic [RECORD_WIDTH-1:0] rec);
        return rec[RECORD_WIDTH-1:DFLOW_LEN_WIDTH];
    endfunction

    function automatic logic [DFLOW_LEN_WIDTH-1:0] rec_len(input logic [RECORD_WIDTH-1:0] rec);
        return rec[DFLOW_LEN_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/dflow_sync_fifo.sv
// Single-clock show-ahead FIFO: rd_data always presents the head entry.
// Writes to a full FIFO and reads from an empty one are ignored.
module dflow_sync_fifo
    import dflow_pkg::*;
#(
    parameter int WIDTH = RECORD_WIDTH,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && (count != (AW+1)'(DEPTH));
    assign do_rd   = rd_en && (count != '0);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array is deliberately not reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dflow_tuple_replayer.sv
// Replays flow records from a QDR address window onto a ready/valid tuple stream,
// with loop count, abort, and read credits bounded by the output FIFO space.
module dflow_tuple_replayer
    import dflow_pkg::*;
#(
    parameter int TUPLE_WIDTH        = DFLOW_TUPLE_WIDTH,
    parameter int LEN_WIDTH          = DFLOW_LEN_WIDTH,
    parameter int MEM_DATA_WIDTH     = 144,
    parameter int MEM_ADDR_WIDTH     = 19,
    parameter int REPLAY_COUNT_WIDTH = 32,
    parameter int FIFO_DEPTH         = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_replay,
    input  logic                          stop_replay,
    input  logic [REPLAY_COUNT_WIDTH-1:0] replay_count,
    input  logic [MEM_ADDR_WIDTH-1:0]     mem_addr_low,
    input  logic [MEM_ADDR_WIDTH-1:0]     mem_addr_high,
    input  logic                          init_calib_complete,
    output logic                          user_app_rd_cmd,
    output logic [MEM_ADDR_WIDTH-1:0]     user_app_rd_addr,
    input  logic                          user_app_rd_valid,
    input  logic [MEM_DATA_WIDTH-1:0]     user_app_rd_data,
    output logic [TUPLE_WIDTH-1:0]        fivetuple_data_out,
    output logic [LEN_WIDTH-1:0]          pkt_len_out,
    output logic                          tuple_out_vld,
    input  logic                          tuple_out_ready,
    output logic                          busy,
    output logic                          compelete_replay,
    output logic [REPLAY_COUNT_WIDTH-1:0] loops_done,
    output logic                          rd_overflow_err
);

    localparam int REC_W = TUPLE_WIDTH + LEN_WIDTH;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    replay_state_t                 state, state_nxt;
    logic [MEM_ADDR_WIDTH-1:0]     addr_lo, addr_hi, cur_addr;
    logic [REPLAY_COUNT_WIDTH-1:0] count_lat;
    logic [CNT_W-1:0]              outstanding, fifo_count;
    logic [CNT_W:0]                in_use;
    logic [REC_W-1:0]              out_rec;
    logic                          start_ok, window_empty, at_high, last_pass;
    logic                          rd_accept, fifo_empty, pop;

    assign start_ok     = start_replay && (state == ST_IDLE || state == ST_DONE);
    assign window_empty = mem_addr_high < mem_addr_low;
    assign at_high      = (cur_addr == addr_hi);
    assign last_pass    = at_high && (count_lat != '0) && (loops_done + 1'b1 == count_lat);
    // Records in the FIFO plus reads in flight never exceed the FIFO depth.
    assign in_use       = {1'b0, fifo_count} + {1'b0, outstanding};
    assign rd_accept    = user_app_rd_valid && (outstanding != '0);
    assign pop          = tuple_out_vld && tuple_out_ready;

    assign user_app_rd_cmd  = (state == ST_ISSUE) && !stop_replay &&
                              (in_use < (CNT_W+1)'(FIFO_DEPTH));
    assign user_app_rd_addr = cur_addr;

    assign busy             = (state == ST_WAIT_CAL) || (state == ST_ISSUE) || (state == ST_DRAIN);
    assign compelete_replay = (state == ST_DONE);
    assign tuple_out_vld    = !fifo_empty;
    assign fivetuple_data_out = tuple_out_vld ? out_rec[REC_W-1:LEN_WIDTH] : '0;
    assign pkt_len_out        = tuple_out_vld ? out_rec[LEN_WIDTH-1:0] : '0;

    // NOTE: next-state is assigned a default first so no path through this block infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                // With calibration already done, WAIT_CAL is passed through in zero cycles.
                if (start_ok) begin
                    if (window_empty)             state_nxt = ST_DONE;
                    else if (init_calib_complete) state_nxt = ST_ISSUE;
                    else                          state_nxt = ST_WAIT_CAL;
                end
            end
            ST_WAIT_CAL: begin
                if (stop_replay)              state_nxt = ST_DRAIN;
                else if (init_calib_complete) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (stop_replay)                        state_nxt = ST_DRAIN;
                else if (user_app_rd_cmd && last_pass)  state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (outstanding == '0 && fifo_empty && !rd_accept) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            addr_lo         <= '0;
            addr_hi         <= '0;
            cur_addr        <= '0;
            count_lat       <= '0;
            loops_done      <= '0;
            outstanding     <= '0;
            rd_overflow_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                addr_lo         <= mem_addr_low;
                addr_hi         <= mem_addr_high;
                cur_addr        <= mem_addr_low;
                count_lat       <= replay_count;
                loops_done      <= '0;
                rd_overflow_err <= 1'b0;
            end else if (user_app_rd_cmd) begin
                if (at_high) begin
                    cur_addr   <= addr_lo;
                    loops_done <= loops_done + 1'b1;
                end else begin
                    cur_addr   <= cur_addr + 1'b1;
                end
            end
            if (user_app_rd_valid && outstanding == '0) begin
                rd_overflow_err <= 1'b1;
            end
            case ({user_app_rd_cmd, rd_accept})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    dflow_sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (start_ok),
        .wr_en   (rd_accept),
        .wr_data (user_app_rd_data[REC_W-1:0]),
        .rd_en   (pop),
        .rd_data (out_rec),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    generate
        if (MEM_DATA_WIDTH > REC_W) begin : g_pad
            logic unused_upper;
            assign unused_upper = |user_app_rd_data[MEM_DATA_WIDTH-1:REC_W];
        end
    endgenerate

endmodule

// File: tb/tb_dflow_tuple_replayer.sv
// Directed bench: a fixed-latency memory model echoes the address into each record,
// expected records are queued at stimulus time and popped by a separate monitor.
module tb_dflow_tuple_replayer;
    import dflow_pkg::*;

    localparam int TW  = 104;
    localparam int LW  = 16;
    localparam int DW  = 144;
    localparam int AW  = 19;
    localparam int CW  = 32;
    localparam int FD  = 16;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          reset, start_replay, stop_replay, init_calib_complete, tuple_out_ready;
    logic [CW-1:0] replay_count, loops_done;
    logic [AW-1:0] mem_addr_low, mem_addr_high, user_app_rd_addr;
    logic          user_app_rd_cmd, user_app_rd_valid, tuple_out_vld, busy, compelete_replay, rd_overflow_err;
    logic [DW-1:0] user_app_rd_data;
    logic [TW-1:0] fivetuple_data_out;
    logic [LW-1:0] pkt_len_out;

    int   total = 0;
    int   bad = 0;
    int   cmd_cnt = 0;
    int   exp_q[$];
    logic sb_en;
    logic spur;

    logic [LAT-1:0] pipe_v = '0;
    logic [AW-1:0]  pipe_a [LAT];

    always #5 clk = ~clk;

    dflow_tuple_replayer dut (
        .clk                 (clk),
        .reset               (reset),
        .start_replay        (start_replay),
        .stop_replay         (stop_replay),
        .replay_count        (replay_count),
        .mem_addr_low        (mem_addr_low),
        .mem_addr_high       (mem_addr_high),
        .init_calib_complete (init_calib_complete),
        .user_app_rd_cmd     (user_app_rd_cmd),
        .user_app_rd_addr    (user_app_rd_addr),
        .user_app_rd_valid   (user_app_rd_valid),
        .user_app_rd_data    (user_app_rd_data),
        .fivetuple_data_out  (fivetuple_data_out),
        .pkt_len_out         (pkt_len_out),
        .tuple_out_vld       (tuple_out_vld),
        .tuple_out_ready     (tuple_out_ready),
        .busy                (busy),
        .compelete_replay    (compelete_replay),
        .loops_done          (loops_done),
        .rd_overflow_err     (rd_overflow_err)
    );

    function automatic logic [RECORD_WIDTH-1:0] make_rec(input logic [AW-1:0] a);
        return {9'h1A5, a, a, a, a, a, a[15:0]};
    endfunction

    // Memory model: fixed read latency, address echoed into the record, upper bits junk.
    always @(posedge clk) begin
        pipe_v    <= {pipe_v[LAT-2:0], user_app_rd_cmd};
        pipe_a[0] <= user_app_rd_addr;
        for (int i = 1; i < LAT; i++) pipe_a[i] <= pipe_a[i-1];
    end
    assign user_app_rd_valid = pipe_v[LAT-1] | spur;
    assign user_app_rd_data  = {24'hFFFFFF, make_rec(pipe_a[LAT-1])};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic                    held = 1'b0;
        logic [RECORD_WIDTH-1:0] held_rec = '0;
        logic [RECORD_WIDTH-1:0] exp_rec;
        forever begin
            @(negedge clk);
            if (user_app_rd_cmd) cmd_cnt++;
            if (sb_en && held) begin
                check("hold_vld", tuple_out_vld, 1'b1);
                check("hold_data", {fivetuple_data_out, pkt_len_out}, held_rec);
            end
            if (sb_en && tuple_out_vld && tuple_out_ready) begin
                check("sb_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    exp_rec = make_rec(AW'(exp_q.pop_front()));
                    check("tuple", fivetuple_data_out, rec_tuple(exp_rec));
                    check("len", pkt_len_out, rec_len(exp_rec));
                end
            end
            held     = sb_en && tuple_out_vld && !tuple_out_ready;
            held_rec = {fivetuple_data_out, pkt_len_out};
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] lo, input logic [AW-1:0] hi, input logic [CW-1:0] cnt);
        mem_addr_low  = lo;
        mem_addr_high = hi;
        replay_count  = cnt;
        start_replay  = 1'b1;
        cyc();
        start_replay  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        @(negedge clk);
        while (!compelete_replay && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_in_time", compelete_replay, 1'b1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rd_cmd"}, user_app_rd_cmd, 1'b0);
        check({tag, "_rd_addr"}, user_app_rd_addr, '0);
        check({tag, "_vld"}, tuple_out_vld, 1'b0);
        check({tag, "_tuple"}, fivetuple_data_out, '0);
        check({tag, "_len"}, pkt_len_out, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_complete"}, compelete_replay, 1'b0);
        check({tag, "_loops"}, loops_done, '0);
        check({tag, "_err"}, rd_overflow_err, 1'b0);
    endtask

    int t1_addrs[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int c0, c_stop;

    initial begin
        reset = 1'b1; start_replay = 1'b0; stop_replay = 1'b0;
        init_calib_complete = 1'b1; tuple_out_ready = 1'b1; spur = 1'b0;
        mem_addr_low = '0; mem_addr_high = '0; replay_count = '0; sb_en = 1'b1;
        fork
            monitor();
        join_none

        // Reset values
        repeat (5) cyc();
        @(negedge clk);
        check_zero_outputs("rst");
        cyc();
        reset = 1'b0;
        repeat (2) cyc();

        // Spurious return while idle is dropped and flagged
        spur = 1'b1;
        cyc();
        spur = 1'b0;
        @(negedge clk);
        check("spur_err", rd_overflow_err, 1'b1);
        check("spur_no_vld", tuple_out_vld, 1'b0);
        cyc();

        // Inverted window: DONE one cycle after start, nothing issued
        c0 = cmd_cnt;
        mem_addr_low = 19'd9; mem_addr_high = 19'd5; replay_count = 32'd1;
        start_replay = 1'b1;
        @(negedge clk);
        check("inv_pre_complete", compelete_replay, 1'b0);
        cyc();
        start_replay = 1'b0;
        @(negedge clk);
        check("inv_complete", compelete_replay, 1'b1);
        check("inv_busy", busy, 1'b0);
        check("inv_loops", loops_done, '0);
        check("inv_err_cleared", rd_overflow_err, 1'b0);
        repeat (5) cyc();
        check("inv_no_cmd", cmd_cnt - c0, 0);

        // Calibration held low for 30 cycles after start
        init_calib_complete = 1'b0;
        exp_q.push_back(2); exp_q.push_back(3);
        c0 = cmd_cnt;
        pulse_start(19'd2, 19'd3, 32'd1);
        repeat (29) cyc();
        @(negedge clk);
        check("cal_busy", busy, 1'b1);
        check("cal_no_cmd", cmd_cnt - c0, 0);
        init_calib_complete = 1'b1;
        cyc();
        @(negedge clk);
        check("cal_first_cmd", user_app_rd_cmd, 1'b1);
        check("cal_first_addr", user_app_rd_addr, 19'd2);
        wait_done(100);
        check("cal_drained", exp_q.size(), 0);
        check("cal_loops", loops_done, 32'd1);
        cyc();

        // Window 0..3, two passes, ready high
        foreach (t1_addrs[i]) exp_q.push_back(t1_addrs[i]);
        c0 = cmd_cnt;
        pulse_start(19'd0, 19'd3, 32'd2);
        wait_done(200);
        check("t1_drained", exp_q.size(), 0);
        check("t1_loops", loops_done, 32'd2);
        check("t1_cmds", cmd_cnt - c0, 8);
        check("t1_busy", busy, 1'b0);
        cyc();

        // Backpressure: credits bound reads in flight, then everything drains in order
        tuple_out_ready = 1'b0;
        for (int i = 0; i < 100; i++) exp_q.push_back(i);
        c0 = cmd_cnt;
        pulse_start(19'd0, 19'd99, 32'd1);
        repeat (200) cyc();
        @(negedge clk);
        check("bp_credit_limit", (cmd_cnt - c0) <= FD, 1'b1);
        check("bp_some_cmds", (cmd_cnt - c0) > 0, 1'b1);
        check("bp_vld_held", tuple_out_vld, 1'b1);
        check("bp_no_err", rd_overflow_err, 1'b0);
        cyc();
        tuple_out_ready = 1'b1;
        wait_done(1000);
        check("bp_drained", exp_q.size(), 0);
        check("bp_cmds", cmd_cnt - c0, 100);
        check("bp_loops", loops_done, 32'd1);
        cyc();

        // Endless replay aborted at cycle 50: 49 reads issued, all delivered
        for (int i = 0; i < 49; i++) exp_q.push_back(i % 10);
        c0 = cmd_cnt;
        pulse_start(19'd0, 19'd9, 32'd0);
        repeat (49) cyc();
        stop_replay = 1'b1;
        c_stop = cmd_cnt;
        cyc();
        stop_replay = 1'b0;
        wait_done(200);
        check("stop_no_cmd_after", cmd_cnt - c_stop, 0);
        check("stop_cmds", cmd_cnt - c0, 49);
        check("stop_loops", loops_done, 32'd4);
        check("stop_drained", exp_q.size(), 0);
        cyc();

        // Reset mid-ISSUE, late returns flagged, then a clean restart
        sb_en = 1'b0;
        pulse_start(19'd0, 19'd99, 32'd1);
        repeat (20) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check_zero_outputs("midrst");
        repeat (4) cyc();
        @(negedge clk);
        check("midrst_late_err", rd_overflow_err, 1'b1);
        repeat (5) cyc();
        exp_q.delete();
        sb_en = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        pulse_start(19'd0, 19'd3, 32'd1);
        wait_done(200);
        check("restart_drained", exp_q.size(), 0);
        check("restart_loops", loops_done, 32'd1);
        check("restart_err", rd_overflow_err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dflow_tuple_replayer.md
# dflow_tuple_replayer

Parametrised replay engine that reads stored flow records (five-tuple plus packet length) back from QDR memory over an address window and emits them on a ready/valid tuple stream. It replaces the fixed-width, always-ready replay path of the dflow generator core. Over that path it adds:
- a configurable loop count;
- an abort command;
- credit-limited outstanding reads;
- full honouring of downstream backpressure through an internal output FIFO.

It sits between the QDR user interface (read side) and the dflow packet builder.

## Interface
- TUPLE_WIDTH, 104, five-tuple width
- LEN_WIDTH, 16, packet length width
- MEM_DATA_WIDTH, 144, QDR user data width (QDR_DATA_WIDTH*QDR_BURST_LENGTH); must be ≥ TUPLE_WIDTH+LEN_WIDTH
- MEM_ADDR_WIDTH, 19, QDR user address width
- REPLAY_COUNT_WIDTH, 32, loop counter width
- FIFO_DEPTH, 16, output FIFO depth, power of two ≥ 2; also the read-credit limit

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- start_replay  in  1  one-cycle start pulse
- stop_replay  in  1  one-cycle abort pulse
- replay_count  in  REPLAY_COUNT_WIDTH  number of passes over the window; 0 = endless
- mem_addr_low / mem_addr_high  in  MEM_ADDR_WIDTH  inclusive window; latched on start
- init_calib_complete  in  1  QDR calibration done
- user_app_rd_cmd  out  1  read request, one per cycle max
- user_app_rd_addr  out  MEM_ADDR_WIDTH  read address
- user_app_rd_valid  in  1  read data strobe
- user_app_rd_data  in  MEM_DATA_WIDTH  record in low bits: {tuple, len}
- fivetuple_data_out  out  TUPLE_WIDTH
- pkt_len_out  out  LEN_WIDTH
- tuple_out_vld  out  1
- tuple_out_ready  in  1
- busy  out  1  high from accepted start until DONE
- compelete_replay  out  1  level, high in DONE until the next accepted start
- loops_done  out  REPLAY_COUNT_WIDTH  completed passes
- rd_overflow_err  out  1  sticky; set when rd_valid arrives with zero outstanding

## Operation
- State machine: IDLE → WAIT_CAL → ISSUE → DRAIN → DONE.
- IDLE → WAIT_CAL on start_replay. Start latches the window and the count, clears loops_done and the error, and empties the FIFO. start_replay is ignored in all states except IDLE and DONE.
- WAIT_CAL → ISSUE when init_calib_complete = 1.
- ISSUE:
  - Assert rd_cmd at cur_addr whenever credit > 0, where credit = FIFO_DEPTH − fifo_count − outstanding.
  - After a command at mem_addr_high: cur_addr wraps to mem_addr_low and loops_done increments.
  - When loops_done reaches a nonzero replay_count, go to DRAIN.
- stop_replay in WAIT_CAL or ISSUE → DRAIN immediately; no further commands are issued.
- DRAIN → DONE when outstanding = 0 and the FIFO is empty and not being written. Every in-flight record is still delivered.
- mem_addr_high < mem_addr_low: zero records. Go straight to DONE one cycle after start with loops_done = 0.
- outstanding: +1 on rd_cmd, −1 on rd_valid, unchanged when both occur in the same cycle.
- rd_valid with outstanding = 0: data dropped, rd_overflow_err set.
- Output word: fivetuple_data_out = rd_data[TUPLE_WIDTH+LEN_WIDTH-1:LEN_WIDTH], pkt_len_out = rd_data[LEN_WIDTH-1:0]. Upper bits are ignored.
- Address and loop arithmetic is unsigned and wraps modulo width. An endless replay never sets compelete_replay unless stopped.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty.
- First rd_cmd is 1 cycle after start when calibration is already complete.
- rd_valid in cycle t → tuple_out_vld in cycle t+1 (FIFO write registered, show-ahead read).
- A record transfers when vld & ready. vld stays high and data stays stable until ready.
- Sustained rate is 1 record/cycle with ready = 1 and memory returning 1/cycle. With ready = 0, at most FIFO_DEPTH commands are in flight and the FIFO never overflows.
- Reset mid-operation aborts at once. Outstanding returns arriving after reset are treated as unexpected (sets rd_overflow_err).

## Structure
- Package dflow_pkg holds:
  - the state enum;
  - the RECORD_WIDTH = TUPLE_WIDTH+LEN_WIDTH constant;
  - the record field-slice functions.
- Sub-module dflow_sync_fifo: single-clock, show-ahead, parametrised width and depth, count output. It is reusable by the store path.

## Test plan
- Window 0..3, count 2, ready = 1, memory echoes address → 8 records with lengths 0,1,2,3,0,1,2,3; loops_done = 2; compelete_replay high.
- Window 0..99, count 1, ready low for 200 cycles → at most 16 rd_cmds issued, no overflow. Releasing ready yields all 100 records in order.
- Count 0, stop_replay at cycle 50 → no rd_cmd after the stop, every outstanding read is delivered, then DONE.
- high = 5, low = 9 → no rd_cmd, DONE one cycle after start, loops_done = 0.
- init_calib_complete low for 30 cycles → no rd_cmd until it rises. Spurious rd_valid while idle sets rd_overflow_err.
- Reset asserted mid-ISSUE → all outputs return to 0 next cycle, and a new start works normally.
